// File: rtl/histo_pkg.sv
// -----------------------------------------------------------------------------
// histo_pkg
// Shared definitions for the histogram readout collector:
//   - state_t   : collector FSM states
//   - DEF_*     : default geometry of the readout stream
//   - sat_add   : unsigned add that clamps at a caller-supplied ceiling
// -----------------------------------------------------------------------------
package histo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_NUM_BINS = 16;
  localparam int DEF_COUNT_W  = 4;
  localparam int DEF_TOTAL_W  = 8;

  // Widened to 33 bits so the carry out of a 32-bit add is never lost
  // before the ceiling compare.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/histo_peak_tracker.sv
// -----------------------------------------------------------------------------
// histo_peak_tracker
// Tracks the largest bin count of a readout pass and the index of the first
// bin that holds it.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   clear     in   restart tracking for a new pass
//   update    in   bin_data/bin_idx form an accepted beat this cycle
//   bin_data  in   bin count of the beat
//   bin_idx   in   index of the beat within the pass
//   peak_cnt  out  largest count seen so far
//   peak_idx  out  index of the first bin holding peak_cnt
// -----------------------------------------------------------------------------
module histo_peak_tracker #(
  parameter int COUNT_W = 4,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  logic [COUNT_W-1:0] bin_data,
  input  logic [IDX_W-1:0]   bin_idx,
  output logic [COUNT_W-1:0] peak_cnt,
  output logic [IDX_W-1:0]   peak_idx
);

  // Strict greater-than: an equal count never displaces the earlier bin, and
  // a zero first beat leaves the cleared (0, 0) result untouched.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      peak_cnt <= '0;
      peak_idx <= '0;
    end else if (update && (bin_data > peak_cnt)) begin
      peak_cnt <= bin_data;
      peak_idx <= bin_idx;
    end
  end

endmodule

// File: rtl/histo_readout_collector.sv
// -----------------------------------------------------------------------------
// histo_readout_collector
// Consumer of the histogram bin readout stream. Frames one readout pass and
// reports the saturating bin total, the peak bin, the beat count and framing
// errors.
// Optional feature macro: HISTO_READOUT_STORE_EN (adds a per-bin store with a
// registered read port rd_addr/rd_data).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   single-cycle arm request (honoured in IDLE and DONE)
//   bin_data   in   bin count beat
//   bin_valid  in   bin_data valid this cycle
//   bin_last   in   final beat of the pass (with bin_valid)
//   busy       out  collector is ARMED or COLLECT
//   done       out  pass complete, results stable
//   peak_idx   out  first bin holding the maximum count
//   peak_cnt   out  maximum count
//   total      out  saturating sum of accepted counts
//   beats      out  accepted beats this pass
//   short_err  out  pass ended before NUM_BINS beats
//   long_err   out  beat arrived after NUM_BINS beats
//   rd_addr    in   (store build) bin to read back
//   rd_data    out  (store build) stored count, one cycle after rd_addr
// -----------------------------------------------------------------------------
module histo_readout_collector
  import histo_pkg::*;
#(
  parameter int NUM_BINS = DEF_NUM_BINS,
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int IDX_W    = $clog2(NUM_BINS),
  parameter int TOTAL_W  = DEF_TOTAL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] bin_data,
  input  logic               bin_valid,
  input  logic               bin_last,
`ifdef HISTO_READOUT_STORE_EN
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [COUNT_W-1:0] rd_data,
`endif
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   peak_idx,
  output logic [COUNT_W-1:0] peak_cnt,
  output logic [TOTAL_W-1:0] total,
  output logic [IDX_W:0]     beats,
  output logic               short_err,
  output logic               long_err
);

  localparam logic [IDX_W:0] BINS_V    = (IDX_W+1)'(NUM_BINS);
  localparam logic [31:0]    TOTAL_MAX = 32'((64'd1 << TOTAL_W) - 64'd1);

  state_t state;

  logic             active;
  logic             room;
  logic             accept;
  logic             drop;
  logic             arm;
  logic             finish;
  logic             short_hit;
  logic [IDX_W-1:0] bin_idx;

  assign active    = (state == ARMED) || (state == COLLECT);
  assign room      = beats < BINS_V;
  assign accept    = active && bin_valid && room;
  assign drop      = active && bin_valid && !room;
  // start outranks a same-cycle beat in DONE because beats are only taken
  // while active.
  assign arm       = start && ((state == IDLE) || (state == DONE));
  assign finish    = (accept || drop) && bin_last;
  assign short_hit = accept && bin_last && ((beats + (IDX_W+1)'(1)) < BINS_V);
  // The beat counter doubles as the bin index of the current beat.
  assign bin_idx   = beats[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      beats     <= '0;
      total     <= '0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state     <= ARMED;
            busy      <= 1'b1;
            done      <= 1'b0;
            beats     <= '0;
            total     <= '0;
            short_err <= 1'b0;
            long_err  <= 1'b0;
          end
        end
        ARMED, COLLECT: begin
          if (accept) begin
            beats <= beats + (IDX_W+1)'(1);
            total <= TOTAL_W'(sat_add(32'(total), 32'(bin_data), TOTAL_MAX));
          end
          if (short_hit) short_err <= 1'b1;
          if (drop)      long_err  <= 1'b1;
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (accept) begin
            state <= COLLECT;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  histo_peak_tracker #(
    .COUNT_W (COUNT_W),
    .IDX_W   (IDX_W)
  ) u_peak (
    .clk      (clk),
    .reset    (reset),
    .clear    (arm),
    .update   (accept),
    .bin_data (bin_data),
    .bin_idx  (bin_idx),
    .peak_cnt (peak_cnt),
    .peak_idx (peak_idx)
  );

`ifdef HISTO_READOUT_STORE_EN
  logic [COUNT_W-1:0] store [NUM_BINS];

  // accept implies beats < NUM_BINS, so bin_idx is always in range here.
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      for (int i = 0; i < NUM_BINS; i++) store[i] <= '0;
    end else if (accept) begin
      store[bin_idx] <= bin_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (32'(rd_addr) < 32'(NUM_BINS))
      rd_data <= store[rd_addr];
    else
      rd_data <= '0;
  end
`endif

endmodule

// File: tb/tb_histo_readout_collector.sv
module tb_histo_readout_collector;

  localparam int NB = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bin_valid = 1'b0;
  logic       bin_last = 1'b0;
  logic [3:0] bin_data = '0;

  logic       busy, done, short_err, long_err;
  logic [3:0] peak_idx, peak_cnt;
  logic [7:0] total;
  logic [4:0] beats;

  logic       busy6, done6, short6, long6;
  logic [3:0] pidx6, pcnt6;
  logic [5:0] total6;
  logic [4:0] beats6;

`ifdef HISTO_READOUT_STORE_EN
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_data, rd_data6;
`endif

  histo_readout_collector dut (
    .clk(clk), .reset(reset), .start(start), .bin_data(bin_data),
    .bin_valid(bin_valid), .bin_last(bin_last),
`ifdef HISTO_READOUT_STORE_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .busy(busy), .done(done), .peak_idx(peak_idx), .peak_cnt(peak_cnt),
    .total(total), .beats(beats), .short_err(short_err), .long_err(long_err)
  );

  histo_readout_collector #(.TOTAL_W(6)) dut6 (
    .clk(clk), .reset(reset), .start(start), .bin_data(bin_data),
    .bin_valid(bin_valid), .bin_last(bin_last),
`ifdef HISTO_READOUT_STORE_EN
    .rd_addr(rd_addr), .rd_data(rd_data6),
`endif
    .busy(busy6), .done(done6), .peak_idx(pidx6), .peak_cnt(pcnt6),
    .total(total6), .beats(beats6), .short_err(short6), .long_err(long6)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_ARMED, M_COLLECT, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  int    vals[$];
  int    m_short = 0;
  int    m_long = 0;
  int    m_store[NB];
  int    m_rd = 0;

  task automatic model_arm();
    mode = M_ARMED;
    vals.delete();
    m_short = 0;
    m_long = 0;
    for (int i = 0; i < NB; i++) m_store[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input bit l, input int d, input int ra);
    if (r) begin
      m_rd = 0;
      mode = M_IDLE;
      vals.delete();
      m_short = 0;
      m_long = 0;
      for (int i = 0; i < NB; i++) m_store[i] = 0;
      return;
    end
    m_rd = m_store[ra];
    case (mode)
      M_IDLE, M_DONE: if (s) model_arm();
      default: begin
        if (v) begin
          if (vals.size() < NB) begin
            m_store[vals.size()] = d;
            vals.push_back(d);
            if (l) begin
              if (vals.size() < NB) m_short = 1;
              mode = M_DONE;
            end else mode = M_COLLECT;
          end else begin
            m_long = 1;
            if (l) mode = M_DONE;
          end
        end
      end
    endcase
  endtask

  function automatic int exp_total(input int cap);
    int s = 0;
    foreach (vals[i]) s += vals[i];
    return (s > cap) ? cap : s;
  endfunction

  function automatic int exp_peak_cnt();
    int m = 0;
    foreach (vals[i]) if (vals[i] > m) m = vals[i];
    return m;
  endfunction

  function automatic int exp_peak_idx();
    int m = exp_peak_cnt();
    foreach (vals[i]) if (vals[i] == m) return i;
    return 0;
  endfunction

  task automatic compare_all();
    chk("busy", 32'(busy), 32'((mode == M_ARMED) || (mode == M_COLLECT)));
    chk("done", 32'(done), 32'(mode == M_DONE));
    chk("beats", 32'(beats), 32'(vals.size()));
    chk("total", 32'(total), 32'(exp_total(255)));
    chk("total6", 32'(total6), 32'(exp_total(63)));
    chk("peak_cnt", 32'(peak_cnt), 32'(exp_peak_cnt()));
    chk("peak_idx", 32'(peak_idx), 32'(exp_peak_idx()));
    chk("short_err", 32'(short_err), 32'(m_short));
    chk("long_err", 32'(long_err), 32'(m_long));
`ifdef HISTO_READOUT_STORE_EN
    chk("rd_data", 32'(rd_data), 32'(m_rd));
`endif
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input bit l, input int d);
    int ra;
    reset = r; start = s; bin_valid = v; bin_last = l; bin_data = 4'(d);
    ra = 0;
`ifdef HISTO_READOUT_STORE_EN
    ra = int'(rd_addr);
`endif
    @(posedge clk);
    model_step(r, s, v, l, d, ra);
    #1;
    compare_all();
  endtask

  // ---------------- table-driven passes ----------------
  typedef struct {
    string            name;
    int               n;
    int               lastpos;
    logic [16:0][3:0] d;
    int               e_total, e_total6, e_pidx, e_pcnt, e_beats, e_short, e_long;
  } vec_t;

  vec_t vt[6];

  initial begin
    for (int r = 0; r < 6; r++) vt[r].d = '0;
    vt[0].name = "ramp";     vt[0].n = 16; vt[0].lastpos = 15;
    for (int i = 0; i < 16; i++) vt[0].d[i] = 4'(i);
    vt[0].e_total = 120; vt[0].e_total6 = 63; vt[0].e_pidx = 15; vt[0].e_pcnt = 15;
    vt[0].e_beats = 16; vt[0].e_short = 0; vt[0].e_long = 0;

    vt[1].name = "tie";      vt[1].n = 16; vt[1].lastpos = 15;
    vt[1].d[0] = 4'd3; vt[1].d[1] = 4'd9; vt[1].d[2] = 4'd9; vt[1].d[3] = 4'd1;
    vt[1].e_total = 22; vt[1].e_total6 = 22; vt[1].e_pidx = 1; vt[1].e_pcnt = 9;
    vt[1].e_beats = 16; vt[1].e_short = 0; vt[1].e_long = 0;

    vt[2].name = "short";    vt[2].n = 5; vt[2].lastpos = 4;
    vt[2].d[0] = 4'd2; vt[2].d[1] = 4'd7; vt[2].d[2] = 4'd1; vt[2].d[3] = 4'd7; vt[2].d[4] = 4'd3;
    vt[2].e_total = 20; vt[2].e_total6 = 20; vt[2].e_pidx = 1; vt[2].e_pcnt = 7;
    vt[2].e_beats = 5; vt[2].e_short = 1; vt[2].e_long = 0;

    vt[3].name = "long";     vt[3].n = 17; vt[3].lastpos = 16;
    for (int i = 0; i < 17; i++) vt[3].d[i] = 4'd1;
    vt[3].e_total = 16; vt[3].e_total6 = 16; vt[3].e_pidx = 0; vt[3].e_pcnt = 1;
    vt[3].e_beats = 16; vt[3].e_short = 0; vt[3].e_long = 1;

    vt[4].name = "zeros";    vt[4].n = 16; vt[4].lastpos = 15;
    vt[4].e_total = 0; vt[4].e_total6 = 0; vt[4].e_pidx = 0; vt[4].e_pcnt = 0;
    vt[4].e_beats = 16; vt[4].e_short = 0; vt[4].e_long = 0;

    vt[5].name = "sat";      vt[5].n = 16; vt[5].lastpos = 15;
    for (int i = 0; i < 16; i++) vt[5].d[i] = 4'd15;
    vt[5].e_total = 240; vt[5].e_total6 = 63; vt[5].e_pidx = 0; vt[5].e_pcnt = 15;
    vt[5].e_beats = 16; vt[5].e_short = 0; vt[5].e_long = 0;

    // reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_beats", 32'(beats), 0);

    // beat in IDLE is ignored
    cycle(0, 0, 1, 1, 9);
    chk("idle_beat_beats", 32'(beats), 0);
    chk("idle_beat_done", 32'(done), 0);

    for (int r = 0; r < 6; r++) begin
      cycle(0, 1, 0, 0, 0);
      chk({vt[r].name, "_busy_armed"}, 32'(busy), 1);
      for (int i = 0; i < vt[r].n; i++) begin
        if (i == vt[r].lastpos) chk({vt[r].name, "_done_early"}, 32'(done), 0);
        cycle(0, 0, 1, (i == vt[r].lastpos), int'(vt[r].d[i]));
      end
      chk({vt[r].name, "_done"}, 32'(done), 1);
      chk({vt[r].name, "_busy"}, 32'(busy), 0);
      chk({vt[r].name, "_total"}, 32'(total), 32'(vt[r].e_total));
      chk({vt[r].name, "_total6"}, 32'(total6), 32'(vt[r].e_total6));
      chk({vt[r].name, "_pidx"}, 32'(peak_idx), 32'(vt[r].e_pidx));
      chk({vt[r].name, "_pcnt"}, 32'(peak_cnt), 32'(vt[r].e_pcnt));
      chk({vt[r].name, "_beats"}, 32'(beats), 32'(vt[r].e_beats));
      chk({vt[r].name, "_short"}, 32'(short_err), 32'(vt[r].e_short));
      chk({vt[r].name, "_long"}, 32'(long_err), 32'(vt[r].e_long));
      cycle(0, 0, 0, 0, 0);
      chk({vt[r].name, "_done_hold"}, 32'(done), 1);
    end

    // start and beat together in DONE: start wins
    cycle(0, 1, 1, 1, 7);
    chk("done_start_busy", 32'(busy), 1);
    chk("done_start_beats", 32'(beats), 0);
    chk("done_start_total", 32'(total), 0);

    // start mid-COLLECT is ignored, the beat is still taken
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 2);
    cycle(0, 1, 1, 0, 5);
    chk("mid_start_beats", 32'(beats), 4);
    chk("mid_start_busy", 32'(busy), 1);
    cycle(0, 0, 1, 1, 0);
    chk("mid_start_total", 32'(total), 11);
    chk("mid_start_short", 32'(short_err), 1);
    chk("mid_start_done", 32'(done), 1);

    // reset mid-pass
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 12);
    cycle(1, 0, 1, 0, 4);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_total", 32'(total), 0);
    chk("mid_rst_beats", 32'(beats), 0);
    chk("mid_rst_pcnt", 32'(peak_cnt), 0);

`ifdef HISTO_READOUT_STORE_EN
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < NB; i++) cycle(0, 0, 1, (i == NB - 1), i ^ 5);
    for (int i = 0; i < NB; i++) begin
      rd_addr = 4'(i);
      cycle(0, 0, 0, 0, 0);
      chk("store_rd", 32'(rd_data), 32'(i ^ 5));
    end
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < NB; i++) begin
      rd_addr = 4'(i);
      cycle(0, 0, 0, 0, 0);
      chk("store_clr", 32'(rd_data), 0);
    end
`endif

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
`ifdef HISTO_READOUT_STORE_EN
      rd_addr = 4'($urandom_range(0, 15));
`endif
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/histo_readout_collector.md
Name: histo_readout_collector

Overview:
Consumer end of the histogram bin readout stream. Captures the per-bin counts emitted by the histogrammer (count, valid, last-bin marker), frames one readout pass, and reports the bin total, the peak bin index and peak count, plus framing errors. Sits downstream of the histogramming core, driven by the same clock domain, and feeds host-visible status and result outputs.

Parameters:
NUM_BINS, 16, expected beats per readout pass.
COUNT_W, 4, width of one bin count on the stream.
IDX_W, 4, bin index width, equal to clog2(NUM_BINS).
TOTAL_W, 8, width of the accumulated total; must hold NUM_BINS*(2^COUNT_W-1); saturates otherwise.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle arm request.
bin_data  in  COUNT_W  bin count from the histogrammer.
bin_valid  in  1  bin_data is a valid beat this cycle.
bin_last  in  1  qualifies the final beat of a pass; meaningful only with bin_valid.
busy  out  1  high in ARMED or COLLECT.
done  out  1  high in DONE; results stable.
peak_idx  out  IDX_W  index of the first bin holding the maximum count.
peak_cnt  out  COUNT_W  maximum count seen.
total  out  TOTAL_W  saturating sum of all bin counts.
beats  out  IDX_W+1  number of beats accepted this pass.
short_err  out  1  bin_last arrived before NUM_BINS beats.
long_err  out  1  a beat arrived after NUM_BINS beats without bin_last.

Behaviour:
- One clock (clk); reset is synchronous and active-high. reset forces IDLE; every output is 0, all accumulators are 0.
- FSM: IDLE -> ARMED on start; ARMED -> COLLECT on the first accepted beat; ARMED/COLLECT -> DONE on an accepted beat with bin_last=1; DONE -> ARMED on start. No other transitions.
- On entering ARMED, all results, beats and error flags are cleared in the same edge.
- A beat is accepted when bin_valid=1 in ARMED or COLLECT and beats<NUM_BINS. Each accepted beat increments beats and the internal index, and adds bin_data to total, saturating at all-ones. If bin_data>peak_cnt, peak_cnt and peak_idx update to that bin. Ties keep the lower index.
- The first beat of a pass is index 0. A first beat of 0 leaves peak_cnt=0 and peak_idx=0.
- If bin_valid=1 with beats==NUM_BINS: the beat is dropped and long_err is set. If that beat also carries bin_last, go to DONE; otherwise stay in COLLECT.
- If an accepted beat has bin_last=1 with beats+1<NUM_BINS: short_err is set and the FSM goes to DONE with the partial results.
- Latency: results and done are visible on the cycle after the last beat's edge. done stays high until start or reset.
- start in ARMED or COLLECT is ignored. bin_valid in IDLE or DONE is ignored. A beat and start in the same cycle in DONE: start wins and the beat is ignored.
- Mid-pass reset aborts the pass; no partial results survive.

Optional Feature:
- Macro: HISTO_READOUT_STORE_EN.
- Defined: adds rd_addr (in, IDX_W) and rd_data (out, COUNT_W). Each accepted beat is written into a NUM_BINS x COUNT_W register array at its index. rd_data is registered, one cycle after rd_addr. The array is cleared on reset and on entering ARMED; out-of-range writes are never performed.
- Undefined: no array and no rd_* ports; all other behaviour is identical.

Decomposition:
- Package histo_pkg: FSM state enum (IDLE, ARMED, COLLECT, DONE), default NUM_BINS, COUNT_W and TOTAL_W constants, and a saturating-add function.
- Natural sub-module: histo_peak_tracker, holding the compare/update of peak_cnt and peak_idx with lower-index tie-break. The FSM, counters and optional store stay in the top.

Test Plan:
- Reset, start, 16 beats of data 0..15 with bin_last on beat 15 -> done=1 one cycle later, total=120, peak_idx=15, peak_cnt=15, beats=16, no errors.
- Counts {3,9,9,1,...0} over 16 beats -> peak_idx=1, peak_cnt=9 (tie keeps lower index).
- bin_last on beat 5 (index 4) -> done=1, beats=5, short_err=1, long_err=0.
- 17 beats with bin_last only on the 17th -> beat 17 dropped, beats=16, long_err=1, DONE reached.
- TOTAL_W=6, 16 beats of 15 -> total=63 (saturated); start mid-COLLECT ignored; reset mid-pass -> all outputs 0, FSM in IDLE.
- With HISTO_READOUT_STORE_EN defined: a pass of values v[i]=i^5, then rd_addr=i -> rd_data=v[i] one cycle later for every i; a re-arm clears all entries to 0.
